// File: rtl/memgame_pkg.sv
// Shared types for the memory card game: card ids, deck size and the game state encoding.
// Used by the card sequencer and the display FSM.
package memgame_pkg;

  typedef logic [3:0] card_id_t;

  localparam int       NUM_CARDS = 7;
  localparam card_id_t CARD_NONE = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_WAIT_RESP,
    ST_CHECK,
    ST_GAME_OVER
  } game_state_t;

  // Map an LFSR value onto a card id in 1..NUM_CARDS.
  function automatic card_id_t card_from_lfsr(input logic [7:0] s);
    logic [7:0] m;
    m = (s % 8'(NUM_CARDS)) + 8'd1;
    return card_id_t'(m);
  endfunction

endpackage

// File: rtl/card_sequencer_if.sv
// Player keys in, card/score/game-over status out.
// master = key/display side, slave = card_sequencer.
interface card_sequencer_if;

  logic                  start;
  logic                  key_match;
  logic                  key_nomatch;
  memgame_pkg::card_id_t card_displayed;
  logic                  show_game_over_screen;
  logic [7:0]            score;
  logic                  game_active;

  modport master (
    output start, key_match, key_nomatch,
    input  card_displayed, show_game_over_screen, score, game_active
  );

  modport slave (
    input  start, key_match, key_nomatch,
    output card_displayed, show_game_over_screen, score, game_active
  );

endinterface

// File: rtl/card_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), loads seed on reset and advances only when step is high.
// The polynomial is maximal length, so a nonzero seed never reaches the all-zero lock-up state.
module card_lfsr (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] state
);

  logic fb;

  assign fb = state[7] ^ state[5] ^ state[4] ^ state[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= seed;
    end else if (step) begin
      state <= {state[6:0], fb};
    end
  end

endmodule

// File: rtl/card_sequencer.sv
// Memory game sequencer: deals cards, judges same/different answers, keeps score; a new card shows 2 cycles after a correct key edge.
// Define CARD_SEQ_TIMEOUT_EN to make an unanswered card time out into GAME_OVER; otherwise WAIT_RESP waits forever.
module card_sequencer
  import memgame_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 250000000,
  parameter int         GO_HOLD        = 16,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  card_sequencer_if.slave  bus
);

  localparam logic [15:0] GO_LOAD = 16'(GO_HOLD - 1);

  game_state_t state, state_nxt;
  card_id_t    card, prev_card;
  logic [7:0]  score;
  logic [15:0] go_cnt;
  logic [7:0]  lfsr;
  logic        start_q, match_q, nomatch_q;
  logic        start_edge, match_edge, nomatch_edge, any_key;
  logic        ans_match, ans_both, ans_correct;
  logic        timeout;
  logic        go_screen, active;

  assign start_edge   = bus.start & ~start_q;
  assign match_edge   = bus.key_match & ~match_q;
  assign nomatch_edge = bus.key_nomatch & ~nomatch_q;
  assign any_key      = match_edge | nomatch_edge;

  card_lfsr u_card_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .step  (state == ST_DEAL),
    .state (lfsr)
  );

  // First card of a game has nothing to compare against, so any single key is right.
  assign ans_correct = !ans_both &&
                       ((prev_card == CARD_NONE) || (ans_match == (card == prev_card)));

`ifdef CARD_SEQ_TIMEOUT_EN
  localparam logic [27:0] TO_LOAD = 28'(TIMEOUT_CYCLES - 1);
  logic [27:0] to_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == ST_DEAL) begin
      to_cnt <= TO_LOAD;
    end else if (state == ST_WAIT_RESP && to_cnt != '0) begin
      to_cnt <= to_cnt - 28'd1;
    end
  end

  assign timeout = (to_cnt == '0);
`else
  logic [27:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 28'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    go_screen = 1'b0;
    active    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_edge) state_nxt = ST_DEAL;
      end
      ST_DEAL: begin
        active    = 1'b1;
        state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        active = 1'b1;
        if (any_key)      state_nxt = ST_CHECK;
        else if (timeout) state_nxt = ST_GAME_OVER;
      end
      ST_CHECK: begin
        active    = 1'b1;
        state_nxt = ans_correct ? ST_DEAL : ST_GAME_OVER;
      end
      ST_GAME_OVER: begin
        go_screen = 1'b1;
        if (go_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      card      <= CARD_NONE;
      prev_card <= CARD_NONE;
      score     <= '0;
      go_cnt    <= '0;
      ans_match <= 1'b0;
      ans_both  <= 1'b0;
      start_q   <= 1'b1;
      match_q   <= 1'b1;
      nomatch_q <= 1'b1;
    end else begin
      start_q   <= bus.start;
      match_q   <= bus.key_match;
      nomatch_q <= bus.key_nomatch;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            score     <= '0;
            prev_card <= CARD_NONE;
          end
        end
        ST_DEAL: begin
          prev_card <= card;
          card      <= card_from_lfsr(lfsr);
        end
        ST_WAIT_RESP: begin
          if (any_key) begin
            ans_match <= match_edge;
            ans_both  <= match_edge & nomatch_edge;
          end
        end
        ST_CHECK: begin
          if (ans_correct && score != 8'hFF) score <= score + 8'd1;
        end
        ST_GAME_OVER: begin
          if (go_cnt != '0) go_cnt <= go_cnt - 16'd1;
        end
        default: ;
      endcase
      // Both mistake and timeout enter GAME_OVER here, so the blanking is shared.
      if (state_nxt == ST_GAME_OVER && state != ST_GAME_OVER) begin
        card   <= CARD_NONE;
        go_cnt <= GO_LOAD;
      end
    end
  end

  assign bus.card_displayed        = card;
  assign bus.score                 = score;
  assign bus.show_game_over_screen = go_screen;
  assign bus.game_active           = active;

endmodule

// File: tb/tb_card_sequencer.sv
// Self-checking bench for card_sequencer: directed table game plus multi-cycle corner sequences.
module tb_card_sequencer;
  import memgame_pkg::*;

  logic clock = 1'b0;
  logic reset;

  card_sequencer_if bus();

  card_sequencer #(
    .TIMEOUT_CYCLES (100),
    .GO_HOLD        (16),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr;
  card_id_t   m_card, m_prev;
  int         m_score;

  typedef struct {
    logic m;
    logic n;
    int   card;
    int   score;
    logic go;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_deal();
    m_prev = m_card;
    m_card = card_id_t'((m_lfsr % 8'd7) + 8'd1);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic start_game(input string tag);
    bus.start = 1'b1;
    tick();
    check({tag, "_active"}, int'(bus.game_active), 1);
    bus.start = 1'b0;
    tick();
    m_card  = CARD_NONE;
    m_score = 0;
    model_deal();
    check({tag, "_first_card"}, int'(bus.card_displayed), int'(m_card));
  endtask

  // Answers the card on display and follows through CHECK and DEAL (or GAME_OVER).
  task automatic answer(input logic m, input logic n, input string tag, output logic over);
    logic correct;
    int   cnt;
    correct = !(m && n) && (m_prev == CARD_NONE || (m == (m_card == m_prev)));
    bus.key_match   = m;
    bus.key_nomatch = n;
    tick();
    bus.key_match   = 1'b0;
    bus.key_nomatch = 1'b0;
    tick();
    over = !correct;
    if (correct) begin
      if (m_score < 255) m_score++;
      check({tag, "_score"}, int'(bus.score), m_score);
      check({tag, "_go_low"}, int'(bus.show_game_over_screen), 0);
      tick();
      model_deal();
      check({tag, "_next_card"}, int'(bus.card_displayed), int'(m_card));
    end else begin
      check({tag, "_go_high"}, int'(bus.show_game_over_screen), 1);
      check({tag, "_go_card"}, int'(bus.card_displayed), 0);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (bus.show_game_over_screen) cnt++;
        else break;
      end
      check({tag, "_go_cycles"}, cnt, 16);
      check({tag, "_idle"}, int'(bus.game_active), 0);
      check({tag, "_score_held"}, int'(bus.score), m_score);
      m_card = CARD_NONE;
    end
  endtask

  initial begin
    logic over;
    int   n;

    tbl[0] = '{1'b0, 1'b1, 5, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 5, 2, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 3, 3, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1, 4, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1, 4, 1'b1};

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.key_match   = 1'b0;
    bus.key_nomatch = 1'b0;
    m_lfsr  = 8'hA5;
    m_card  = CARD_NONE;
    m_prev  = CARD_NONE;
    m_score = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_card", int'(bus.card_displayed), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_go", int'(bus.show_game_over_screen), 0);
    check("rst_active", int'(bus.game_active), 0);

    // Game 1: hand-computed card sequence from seed A5 is 5,5,3,1,1.
    start_game("g1");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tbl%0d_card", i), int'(bus.card_displayed), tbl[i].card);
      answer(tbl[i].m, tbl[i].n, $sformatf("tbl%0d", i), over);
      check($sformatf("tbl%0d_score", i), int'(bus.score), tbl[i].score);
      check($sformatf("tbl%0d_over", i), int'(over), int'(tbl[i].go));
    end

    // Game 2: both keys in one cycle on the first card.
    start_game("g2");
    answer(1'b1, 1'b1, "both_keys", over);
    check("both_keys_over", int'(over), 1);

    // Game 3: 300 correct answers, score must saturate.
    start_game("g3");
    for (int i = 0; i < 300; i++) begin
      answer((m_prev != CARD_NONE) && (m_card == m_prev),
             !((m_prev != CARD_NONE) && (m_card == m_prev)),
             $sformatf("sat%0d", i), over);
      if (over) break;
    end
    check("sat_final", int'(bus.score), 255);

`ifdef CARD_SEQ_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.show_game_over_screen) begin
        n = i;
        break;
      end
    end
    check("timeout_cycles", n, 100);
    for (int i = 0; i < 40; i++) begin
      if (!bus.show_game_over_screen) break;
      tick();
    end
    check("timeout_idle", int'(bus.game_active), 0);
    check("timeout_score_held", int'(bus.score), 255);
    start_game("g4");
`else
    repeat (10000) tick();
    check("no_timeout_active", int'(bus.game_active), 1);
    check("no_timeout_go", int'(bus.show_game_over_screen), 0);
    check("no_timeout_card", int'(bus.card_displayed), int'(m_card));
`endif

    // Reset in WAIT_RESP with a key held: reset wins, and the held key never yields an edge.
    bus.key_match = 1'b1;
    reset         = 1'b1;
    tick();
    check("midrst_card", int'(bus.card_displayed), 0);
    check("midrst_score", int'(bus.score), 0);
    check("midrst_go", int'(bus.show_game_over_screen), 0);
    check("midrst_active", int'(bus.game_active), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("midrst_stay_idle", int'(bus.game_active), 0);
    m_lfsr = 8'hA5;
    start_game("g5");
    check("g5_seed_card", int'(bus.card_displayed), 5);
    repeat (3) tick();
    check("held_key_active", int'(bus.game_active), 1);
    check("held_key_card", int'(bus.card_displayed), 5);
    check("held_key_score", int'(bus.score), 0);
    bus.key_match = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_sequencer.md
CARD_SEQUENCER -- requirements
Module: card_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 250000000, response window per card in clock cycles (28-bit counter).
REQ-002 Parameter GO_HOLD, default 16, number of cycles show_game_over_screen stays high.
REQ-003 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR load value.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level from start key; rising edge begins a game.
REQ-007 key_match  input  1  level; rising edge means the player answers "same as previous card".
REQ-008 key_nomatch  input  1  level; rising edge means the player answers "different from previous card".
REQ-009 card_displayed  output  4  current card id, 1..7; 0 means no card.
REQ-010 show_game_over_screen  output  1  high for GO_HOLD cycles after a mistake.
REQ-011 score  output  8  count of correct answers in the current game.
REQ-012 game_active  output  1  high in DEAL, WAIT_RESP and CHECK.

Function
REQ-013 States: IDLE, DEAL, WAIT_RESP, CHECK, GAME_OVER, plus registered edge detectors on start, key_match and key_nomatch.
REQ-014 IDLE: on a start edge, clear score and prev_card, then go to DEAL; key edges are ignored.
REQ-015 DEAL lasts 1 cycle: prev_card <= card_displayed, card_displayed <= (lfsr mod 7)+1, LFSR steps once, timeout counter loads TIMEOUT_CYCLES-1, next state is WAIT_RESP.
REQ-016 LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps only in DEAL, never reaches 0.
REQ-017 WAIT_RESP: the first key edge (match or nomatch) goes to CHECK with the answer latched; the counter decrements each cycle.
REQ-018 If both key edges arrive in the same cycle, the answer is a mistake.
REQ-019 First card of a game (prev_card==0): any single key edge counts as correct.
REQ-020 CHECK lasts 1 cycle: correct means (match and card==prev) or (nomatch and card!=prev).
REQ-021 Correct answer: score increments, saturating at 255, and the next state is DEAL.
REQ-022 Mistake: the next state is GAME_OVER.
REQ-023 GAME_OVER: show_game_over_screen is high for exactly GO_HOLD cycles, card_displayed=0, then the state returns to IDLE; score holds its value until the next start.
REQ-024 Key edges outside WAIT_RESP are discarded, not queued.
REQ-025 A start edge outside IDLE is ignored.

Reset
REQ-026 On reset the following values apply:
- state = IDLE
- card_displayed = 0, prev_card = 0
- score = 0
- show_game_over_screen = 0, game_active = 0
- lfsr = LFSR_SEED
- counters = 0
- edge-detector history registers = 1, so a key held through reset produces no edge.
REQ-027 Reset asserted mid-game takes effect on the next clock edge from any state and overrides all other inputs.

Configuration
REQ-028 Macro CARD_SEQ_TIMEOUT_EN:
- Defined: counter expiry in WAIT_RESP (counter==0 with no key edge) is a mistake and leads to GAME_OVER.
- Not defined: the counter is not built and WAIT_RESP waits indefinitely.

Structure
REQ-029 Shared package memgame_pkg holds:
- card_id_t (4-bit)
- NUM_CARDS=7
- CARD_NONE=0
- the state enumeration, shared with the display FSM.
REQ-030 One sub-module, card_lfsr (seed, step enable, 8-bit state out), instantiated once.

Verification
REQ-031 Reset, then a start edge: after 2 cycles game_active=1, card_displayed is in 1..7 and equals the bench LFSR model for seed 8'hA5.
REQ-032 First card, key_nomatch edge: score=1 and a new card appears exactly 2 cycles after the edge (CHECK, DEAL).
REQ-033 Play 300 correct answers against the model: score sticks at 255 and never wraps.
REQ-034 Wrong answer, or both keys in the same cycle: show_game_over_screen is high for exactly 16 cycles, card_displayed=0, then IDLE with score held.
REQ-035 With CARD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, no key press: GAME_OVER is entered 100 cycles after WAIT_RESP; without the macro the block is still in WAIT_RESP after 10000 cycles.
REQ-036 Reset asserted in WAIT_RESP with a key held high: all outputs are at reset values next cycle and no spurious edge follows.
